imem_loader: RTL and testbench

Boot-time instruction memory for the pipelined core. It receives a program as a byte stream over a valid/ready handshake, packs the bytes into 32-bit words and stores them in an internal word array. It holds the core in reset until loading completes, then serves instruction fetches combinationally. It sits directly upstream of the core's fetch stage: it drives the core's instruction-memory output from the core's word-addressed PC.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/word_assembler.sv | 28 ++
 rtl/imem_loader.sv | 95 +++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;
  localparam int unsigned LEN_W            = 16;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; pulses word_valid on byte 3.
module word_assembler (
  input  logic        clk,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] hold;

  always_ff @(posedge clk) begin
    if (clr) begin
      byte_cnt <= '0;
      hold     <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      hold     <= {byte_in, hold[23:8]};
    end
  end

  // Earlier bytes have shifted down, so byte 0 sits in hold[7:0] when byte 3 arrives.
  assign word_valid = byte_valid && (byte_cnt == 2'd3);
  assign word       = {byte_in, hold};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into a word array, holds the core until done,
// then serves combinational instruction fetches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        core_hold,
  output logic        load_done,
  output logic [15:0] words_loaded,
  output logic        overflow
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  len;
  logic [31:0]       mem [DEPTH];
  logic              word_valid;
  logic [31:0]       word;
  logic              in_range;
  logic              last_word;

  assign in_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign load_done = (state == S_DONE);
  assign in_range  = 32'(words_loaded) < DEPTH_W;
  assign last_word = (words_loaded == len - 16'd1);

  word_assembler u_word_assembler (
    .clk        (clk),
    .clr        (clr),
    .byte_valid (in_valid && (state == S_DATA)),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LEN_LO;
      S_LEN_LO: if (in_valid) state_next = S_LEN_HI;
      S_LEN_HI: if (in_valid) state_next = ({in_data, len[7:0]} == '0) ? S_DONE : S_DATA;
      S_DATA:   if (word_valid && last_word) state_next = S_DONE;
      S_DONE:   if (start) state_next = S_LEN_LO;
      default:  state_next = S_IDLE;
    endcase
  end

  // core_hold is registered from the next state so it tracks DONE without a lag cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= S_IDLE;
      core_hold    <= 1'b1;
      len          <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
    end else begin
      state     <= state_next;
      core_hold <= (state_next != S_DONE);
      if (state == S_LEN_LO && in_valid) len[7:0]  <= in_data;
      if (state == S_LEN_HI && in_valid) len[15:8] <= in_data;
      if (state == S_DATA && word_valid) begin
        words_loaded <= words_loaded + 16'd1;
        if (!in_range) overflow <= 1'b1;
      end
      if ((state == S_IDLE || state == S_DONE) && start) begin
        words_loaded <= '0;
        overflow     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
    end else if (state == S_DATA && word_valid && in_range) begin
      mem[words_loaded[AW-1:0]] <= word;
    end
  end

  assign fetch_data = (fetch_addr < DEPTH_W) ? mem[fetch_addr[AW-1:0]] : NOP_WORD;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected words queued per load, checked as each word lands.
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        core_hold;
  logic        load_done;
  logic [15:0] words_loaded;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] prog [$];

  imem_loader #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fetch_addr   (fetch_addr),
    .fetch_data   (fetch_data),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .words_loaded (words_loaded),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    if (stall) begin
      in_valid = 1'b0;
      in_data  = 8'hff;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int c = 0; c < 8 && !in_ready; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL byte_accept in_ready=%0b required 1 (byte %02h)", in_ready, b);
      errors++;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h5a;
  endtask

  task automatic check_mem(input string tag);
    logic [31:0] addrs [2];
    addrs[0] = 32'd1000;
    addrs[1] = 32'h8000_0000;
    for (int a = 0; a < DEPTH + 2; a++) begin
      fetch_addr = 32'(a);
      #1;
      checks++;
      if (fetch_data !== ((a < DEPTH) ? model_mem[a] : NOP)) begin
        $display("FAIL %s mem[%0d] got %08h required %08h", tag, a, fetch_data,
                 (a < DEPTH) ? model_mem[a] : NOP);
        errors++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      fetch_addr = addrs[i];
      #1;
      checks++;
      if (fetch_data !== NOP) begin
        $display("FAIL %s far_addr %08h got %08h required %08h", tag, addrs[i], fetch_data, NOP);
        errors++;
      end
    end
    fetch_addr = '0;
  endtask

  task automatic run_load(input logic [15:0] len, input bit stall);
    logic [31:0] word;
    logic [31:0] exp_word;
    for (int w = 0; w < int'(len); w++) exp_q.push_back((w < DEPTH) ? prog[w] : NOP);
    send_byte(len[7:0], stall);
    send_byte(len[15:8], stall);
    if (len == 16'd0) begin
      checks++;
      if (core_hold !== 1'b0 || load_done !== 1'b1) begin
        $display("FAIL len0_done core_hold=%0b load_done=%0b required 0/1", core_hold, load_done);
        errors++;
      end
    end
    for (int w = 0; w < int'(len); w++) begin
      word = prog[w];
      fetch_addr = 32'(w);
      for (int k = 0; k < 4; k++) begin
        if (k == 3) begin
          checks++;
          if (core_hold !== 1'b1) begin
            $display("FAIL hold_before_last word %0d core_hold=%0b required 1", w, core_hold);
            errors++;
          end
        end
        send_byte(word[8*k +: 8], stall);
      end
      if (w < DEPTH) model_mem[w] = word;
      exp_word = exp_q.pop_front();
      checks++;
      if (fetch_data !== exp_word) begin
        $display("FAIL word_write addr %0d got %08h required %08h", w, fetch_data, exp_word);
        errors++;
      end
      checks++;
      if (core_hold !== (w != int'(len) - 1)) begin
        $display("FAIL hold_after_word %0d core_hold=%0b required %0b", w, core_hold,
                 (w != int'(len) - 1));
        errors++;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (core_hold !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0 ||
        words_loaded !== 16'd0 || overflow !== 1'b0) begin
      $display("FAIL %s hold/ready/done/words/ovf = %0b/%0b/%0b/%0d/%0b required 1/0/0/0/0",
               tag, core_hold, in_ready, load_done, words_loaded, overflow);
      errors++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    reset_model();
    @(posedge clk); #1;
    check_idle_outputs("reset");
    check_mem("reset");
  endtask

  task automatic test_basic();
    prog = {32'h0010_0093, 32'h0020_0113};
    pulse_start();
    checks++;
    if (in_ready !== 1'b1 || core_hold !== 1'b1) begin
      $display("FAIL start_len_lo in_ready=%0b core_hold=%0b required 1/1", in_ready, core_hold);
      errors++;
    end
    run_load(16'd2, 1'b0);
    checks++;
    if (words_loaded !== 16'd2 || load_done !== 1'b1 || overflow !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL basic_status words=%0d done=%0b ovf=%0b ready=%0b required 2/1/0/0",
               words_loaded, load_done, overflow, in_ready);
      errors++;
    end
    check_mem("basic");
  endtask

  task automatic test_stall();
    prog = {32'h0010_0093, 32'h0020_0113};
    pulse_start();
    checks++;
    if (words_loaded !== 16'd0 || core_hold !== 1'b1 || load_done !== 1'b0) begin
      $display("FAIL restart words=%0d hold=%0b done=%0b required 0/1/0",
               words_loaded, core_hold, load_done);
      errors++;
    end
    run_load(16'd2, 1'b1);
    checks++;
    if (words_loaded !== 16'd2) begin
      $display("FAIL stall_words got %0d required 2", words_loaded);
      errors++;
    end
    check_mem("stall");
  endtask

  task automatic test_overflow();
    prog = {};
    for (int i = 0; i < DEPTH + 1; i++) prog.push_back($urandom);
    pulse_start();
    run_load(16'(DEPTH + 1), 1'b0);
    checks++;
    if (overflow !== 1'b1 || words_loaded !== 16'(DEPTH + 1) || load_done !== 1'b1) begin
      $display("FAIL overflow ovf=%0b words=%0d done=%0b required 1/%0d/1",
               overflow, words_loaded, load_done, DEPTH + 1);
      errors++;
    end
    check_mem("overflow");
  endtask

  task automatic test_len0();
    pulse_start();
    checks++;
    if (overflow !== 1'b0 || words_loaded !== 16'd0) begin
      $display("FAIL restart_clear ovf=%0b words=%0d required 0/0", overflow, words_loaded);
      errors++;
    end
    run_load(16'd0, 1'b0);
    checks++;
    if (words_loaded !== 16'd0 || in_ready !== 1'b0) begin
      $display("FAIL len0_status words=%0d ready=%0b required 0/0", words_loaded, in_ready);
      errors++;
    end
    check_mem("len0");
  endtask

  task automatic test_clr_mid();
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = 32'hdead_beef;
    w1 = 32'h1234_5678;
    pulse_start();
    send_byte(8'd2, 1'b0);
    send_byte(8'd0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 1'b0);
    for (int k = 0; k < 2; k++) send_byte(w1[8*k +: 8], 1'b0);
    pulse_start();
    checks++;
    if (in_ready !== 1'b1 || core_hold !== 1'b1 || words_loaded !== 16'd1) begin
      $display("FAIL start_ignored ready=%0b hold=%0b words=%0d required 1/1/1",
               in_ready, core_hold, words_loaded);
      errors++;
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    reset_model();
    check_idle_outputs("clr_mid");
    check_mem("clr_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_len0();
    test_clr_mid();
    test_basic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
